// File: rtl/gate_ic_emulator.sv
// Virtual 8-input gate DUT for the IC tester: synchronises the stimulus pins, debounces them and answers after a programmable delay.
// Optional build macro GATE_IC_FAULT_INJECT_EN adds a fault_mode port that corrupts op1 combinationally.
`timescale 1ns/1ps
module gate_ic_emulator #(
    parameter int STABLE_CYCLES = 4,
    parameter int RESP_DELAY    = 16,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] gate_sel,
    input  logic [7:0] pin_in,
`ifdef GATE_IC_FAULT_INJECT_EN
    input  logic [1:0] fault_mode,
`endif
    output logic       op1,
    output logic       busy,
    output logic [7:0] resp_count
);

    typedef enum logic [1:0] {IDLE, STABLE, DELAY, UPDATE} state_t;

    // Acceptance and the DELAY exit fire on the cycle whose increment reaches the final count,
    // so the end-to-end latency is 2 + STABLE_CYCLES + RESP_DELAY edges.
    localparam logic [CNT_W-1:0] STAB_SAT  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_ACC  = CNT_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'((RESP_DELAY >= 2) ? RESP_DELAY - 2 : 0);
    localparam bit               SKIP_DLY  = (RESP_DELAY == 1);

    state_t           state, state_n;
    logic [7:0]       sync1, s_in, s_prev;
    logic [CNT_W-1:0] stab_cnt, stab_n, dly_cnt, dly_n;
    logic [7:0]       acc_pat, acc_n, last_pat;
    logic             last_valid, do_update, gate_q, gate_f, changed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            s_in   <= '0;
            s_prev <= '0;
        end else begin
            sync1  <= pin_in;
            s_in   <= sync1;
            s_prev <= s_in;
        end
    end

    assign changed = (s_in != s_prev);

    always_comb begin
        state_n   = state;
        stab_n    = stab_cnt;
        dly_n     = dly_cnt;
        acc_n     = acc_pat;
        do_update = 1'b0;
        case (state)
            IDLE: begin
                stab_n = '0;
                dly_n  = '0;
                if (enable) state_n = STABLE;
            end
            STABLE: begin
                if (changed) begin
                    stab_n = '0;
                end else if (stab_cnt >= STAB_ACC) begin
                    stab_n = STAB_SAT;
                    if (!last_valid || (s_in != last_pat)) begin
                        acc_n   = s_in;
                        dly_n   = '0;
                        state_n = SKIP_DLY ? UPDATE : DELAY;
                    end
                end else begin
                    stab_n = stab_cnt + CNT_W'(1);
                end
            end
            DELAY: begin
                if (s_in != acc_pat) begin
                    state_n = STABLE;
                    stab_n  = '0;
                    dly_n   = '0;
                end else begin
                    dly_n = dly_cnt + CNT_W'(1);
                    if (dly_cnt >= DLY_LAST) state_n = UPDATE;
                end
            end
            UPDATE: begin
                do_update = 1'b1;
                stab_n    = '0;
                dly_n     = '0;
                state_n   = enable ? STABLE : IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Dropping enable wins immediately everywhere except UPDATE, which finishes first.
        if (!enable && (state != UPDATE)) begin
            state_n = IDLE;
            stab_n  = '0;
            dly_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            stab_cnt <= '0;
            dly_cnt  <= '0;
            acc_pat  <= '0;
        end else begin
            state    <= state_n;
            stab_cnt <= stab_n;
            dly_cnt  <= dly_n;
            acc_pat  <= acc_n;
        end
    end

    always_comb begin
        case (gate_sel)
            3'b000:  gate_f = &acc_pat;
            3'b001:  gate_f = ~&acc_pat;
            3'b010:  gate_f = |acc_pat;
            3'b011:  gate_f = ~|acc_pat;
            3'b100:  gate_f = ^acc_pat;
            3'b101:  gate_f = ~^acc_pat;
            default: gate_f = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q     <= 1'b0;
            last_pat   <= '0;
            last_valid <= 1'b0;
            resp_count <= '0;
        end else if (do_update) begin
            gate_q     <= gate_f;
            last_pat   <= acc_pat;
            last_valid <= 1'b1;
            resp_count <= resp_count + 8'd1;
        end
    end

    assign busy = ((state == STABLE) && (stab_cnt != STAB_SAT)) || (state == DELAY);

`ifdef GATE_IC_FAULT_INJECT_EN
    always_comb begin
        case (fault_mode)
            2'b01:   op1 = 1'b0;
            2'b10:   op1 = 1'b1;
            2'b11:   op1 = ~gate_q;
            default: op1 = gate_q;
        endcase
    end
`else
    assign op1 = gate_q;
`endif

endmodule

// File: tb/tb_gate_ic_emulator.sv
// Directed bench for gate_ic_emulator: expected gate answers are queued as stimulus is driven and checked at each update.
`timescale 1ns/1ps
module tb_gate_ic_emulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] gate_sel = 3'b001;
    logic [7:0] pin_in = 8'h00;
    logic       op1, busy;
    logic [7:0] resp_count;
`ifdef GATE_IC_FAULT_INJECT_EN
    logic [1:0] fault_mode = 2'b00;
`endif

    int errors = 0;
    int checks = 0;
    int exp_count = 0;
    bit exp_op1 = 1'b0;
    bit exp_q[$];

    always #10 clk = ~clk;

    gate_ic_emulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .gate_sel   (gate_sel),
        .pin_in     (pin_in),
`ifdef GATE_IC_FAULT_INJECT_EN
        .fault_mode (fault_mode),
`endif
        .op1        (op1),
        .busy       (busy),
        .resp_count (resp_count)
    );

    // Reference gate built from the population count rather than reduction operators.
    function automatic bit gate_model(input logic [7:0] p, input logic [2:0] sel);
        int ones;
        ones = $countones(p);
        case (sel)
            3'd0:    return ones == 8;
            3'd1:    return ones != 8;
            3'd2:    return ones != 0;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pat, input logic [2:0] sel, input bit answer);
        @(negedge clk);
        pin_in   = pat;
        gate_sel = sel;
        if (answer) exp_q.push_back(gate_model(pat, sel));
    endtask

    // Waits (bounded) for the next update, then checks latency, op1 against the queue and resp_count.
    task automatic waitUpdate(input string tag, input int lat, input bit exact);
        int n;
        logic [7:0] start;
        n = 0;
        start = resp_count;
        while ((resp_count === start) && (n < 60)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (resp_count === start) begin
            checkOutput({tag, "_timeout"}, resp_count, start + 8'd1);
            return;
        end
        exp_count++;
        if (exact) checkOutput({tag, "_latency"}, n, lat);
        else       checkOutput({tag, "_latency_max"}, (n <= lat), 1);
        if (exp_q.size() > 0) begin
            exp_op1 = exp_q.pop_front();
            checkOutput({tag, "_op1"}, op1, exp_op1);
        end else begin
            checkOutput({tag, "_unexpected_update"}, resp_count, start);
        end
        checkOutput({tag, "_count"}, resp_count, 8'(exp_count));
    endtask

    task automatic holdCheck(input string tag, input int cycles);
        repeat (cycles) @(negedge clk);
        checkOutput({tag, "_hold_op1"}, op1, exp_op1);
        checkOutput({tag, "_hold_count"}, resp_count, 8'(exp_count));
        checkOutput({tag, "_hold_busy"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_op1", op1, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_count", resp_count, 0);

        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        exp_q.push_back(gate_model(8'h00, 3'd1));
        waitUpdate("first", 22, 1'b0);

        // Reset lands while the 0xFF answer is in DELAY with dly_cnt=8.
        applyStimulus(8'hFF, 3'd1, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_delay_busy", busy, 1);
        #5;
        rst_n  = 1'b0;
        pin_in = 8'h00;
        #1;
        checkOutput("async_rst_op1", op1, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_count", resp_count, 0);
        exp_count = 0;
        exp_op1   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(gate_model(8'h00, 3'd1));
        waitUpdate("rst_release", 22, 1'b0);

        // NAND sweep; 0x00 is already answered.
        applyStimulus(8'h00, 3'd1, 1'b0);
        holdCheck("nand_00", 40);
        applyStimulus(8'h7F, 3'd1, 1'b1);
        waitUpdate("nand_7f", 22, 1'b1);
        holdCheck("nand_7f", 18);
        applyStimulus(8'hFF, 3'd1, 1'b1);
        waitUpdate("nand_ff", 22, 1'b1);
        holdCheck("nand_ff", 18);

        // Two-cycle glitch on an answered pattern.
        applyStimulus(8'h00, 3'd1, 1'b1);
        waitUpdate("glitch_base", 22, 1'b1);
        holdCheck("glitch_base", 18);
        applyStimulus(8'hFF, 3'd1, 1'b0);
        @(negedge clk);
        applyStimulus(8'h00, 3'd1, 1'b0);
        holdCheck("glitch", 40);

        // Abort the 0x00 answer at dly_cnt=10 by moving to 0x01.
        applyStimulus(8'hFF, 3'd1, 1'b1);
        waitUpdate("abort_pre", 22, 1'b1);
        holdCheck("abort_pre", 18);
        applyStimulus(8'h00, 3'd1, 1'b0);
        repeat (16) @(posedge clk);
        applyStimulus(8'h01, 3'd1, 1'b1);
        waitUpdate("abort", 22, 1'b1);
        holdCheck("abort", 18);

        applyStimulus(8'h07, 3'd4, 1'b1);
        waitUpdate("xor_07", 22, 1'b1);
        holdCheck("xor_07", 18);
        applyStimulus(8'h03, 3'd4, 1'b1);
        waitUpdate("xor_03", 22, 1'b1);
        holdCheck("xor_03", 18);
        applyStimulus(8'h10, 3'd2, 1'b1);
        waitUpdate("or_10", 22, 1'b1);
        holdCheck("or_10", 18);
        applyStimulus(8'h05, 3'd6, 1'b1);
        waitUpdate("sel6_05", 22, 1'b1);
        holdCheck("sel6_05", 18);
        applyStimulus(8'hFF, 3'd0, 1'b1);
        waitUpdate("and_ff", 22, 1'b1);
        holdCheck("and_ff", 18);
        applyStimulus(8'h00, 3'd3, 1'b1);
        waitUpdate("nor_00", 22, 1'b1);
        holdCheck("nor_00", 18);

        // Disabled: pins toggle freely, nothing is answered; re-enable keeps the old pattern.
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            pin_in = 8'($urandom_range(1, 255));
        end
        holdCheck("disabled", 1);
        pin_in = 8'h00;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        holdCheck("reenable", 40);

`ifdef GATE_IC_FAULT_INJECT_EN
        applyStimulus(8'h55, 3'd1, 1'b1);
        waitUpdate("fault_base", 22, 1'b1);
        @(negedge clk);
        fault_mode = 2'b01;
        #1;
        checkOutput("fault_stuck0", op1, 0);
        fault_mode = 2'b11;
        #1;
        checkOutput("fault_invert", op1, 0);
        fault_mode = 2'b10;
        #1;
        checkOutput("fault_stuck1", op1, 1);
        fault_mode = 2'b00;
        #1;
        checkOutput("fault_none", op1, 1);
        fault_mode = 2'b11;
        holdCheck("fault_invert_hold", 20);
        fault_mode = 2'b00;
        #1;
        checkOutput("fault_count", resp_count, 8'(exp_count));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
